// File: rtl/dz_scan.sv
// dz_scan: bicolor 8x8 dot-matrix row-scan driver with a tear-free image double buffer.
// Latency: st in IDLE -> one ghost-blank cycle, then row 0 lit; fail -> colour one cycle later.
// Backpressure: none. st is always accepted; within a frame the last strobe wins.
//
// Parameters: DIV (clocks per row dwell, 2..65535), BLINK_FRAMES (frames per blink half-period).
// Optional feature macro: DZ_SCAN_BLINK_EN (green "fail" image blinks instead of staying lit).
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   st, num[3:0]    - load strobe and image index (0-7 hatch, 8-11 animals, 12-15 blank)
//   fail            - colour select: 0 red, 1 green
//   row[7:0]        - active-low row select
//   colg/colr[7:0]  - active-high green/red column data
//   frame_done      - pulse in the last cycle of the row-7 dwell
module dz_scan #(
    parameter int unsigned DIV          = 1000,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       st,
    input  logic [3:0] num,
    input  logic       fail,
    output logic [7:0] row,
    output logic [7:0] colg,
    output logic [7:0] colr,
    output logic       frame_done
);

    if (DIV < 2 || DIV > 65535 || BLINK_FRAMES < 1) begin : g_bad_param
        $error("dz_scan: DIV must be 2..65535 and BLINK_FRAMES >= 1");
    end

    localparam logic [15:0] PSC_LAST = 16'(DIV - 1);

    // Image table, row r in bits [8r+7:8r] (row 7 is the leftmost byte).
    localparam logic [63:0] IMG [16] = '{
        64'h183C7E7E7E7E3C18,  // 0  whole egg
        64'h183C7E7E6E7E3C18,  // 1  first crack
        64'h183C7E6E567E3C18,  // 2
        64'h183C6E56667E3C18,  // 3
        64'h18245A66567E3C18,  // 4
        64'h1824424256663C18,  // 5
        64'h0024424242663C18,  // 6
        64'h0000424242663C18,  // 7  shell open
        64'h0066FFFF7E3C1800,  // 8  animal: heart-chick
        64'h3C4299A581A5423C,  // 9  animal: face
        64'h1818183C7EFF1818,  // 10 animal: bird
        64'h42E77E3C3C7EE742,  // 11 animal: bug
        64'h0000000000000000,  // 12 blank
        64'h0000000000000000,  // 13 blank
        64'h0000000000000000,  // 14 blank
        64'h0000000000000000   // 15 blank
    };

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t      state_q, state_d;
    logic [15:0] psc_q, psc_d;
    logic [2:0]  rowc_q, rowc_d;
    logic [3:0]  cur_q, cur_d;
    logic [3:0]  pend_q, pend_d;
    logic        pend_v_q, pend_v_d;
    logic [7:0]  row_q, row_d;
    logic [7:0]  colg_q, colg_d;
    logic [7:0]  colr_q, colr_d;

    logic [63:0] img_w;
    logic [7:0]  img_byte;
    logic        boundary;
    logic        dark;

    assign img_w    = IMG[cur_q];
    assign img_byte = img_w[{rowc_q, 3'b000} +: 8];
    assign boundary = (state_q == S_SCAN) && (rowc_q == 3'd7) && (psc_q == PSC_LAST);

`ifdef DZ_SCAN_BLINK_EN
    logic [15:0] bcnt_q, bcnt_d;
    logic        dark_q, dark_d;

    // Blink phase only runs while fail is held; it restarts lit whenever fail drops.
    always_comb begin
        bcnt_d = bcnt_q;
        dark_d = dark_q;
        if (!fail) begin
            bcnt_d = '0;
            dark_d = 1'b0;
        end else if (boundary) begin
            if (bcnt_q == 16'(BLINK_FRAMES - 1)) begin
                bcnt_d = '0;
                dark_d = ~dark_q;
            end else begin
                bcnt_d = bcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_q <= '0;
            dark_q <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            dark_q <= dark_d;
        end
    end

    assign dark = dark_q;
`else
    assign dark = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        psc_d    = psc_q;
        rowc_d   = rowc_q;
        cur_d    = cur_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        row_d    = 8'hFF;
        colg_d   = 8'h00;
        colr_d   = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (st) begin
                    state_d  = S_SCAN;
                    cur_d    = num;
                    pend_v_d = 1'b0;
                    psc_d    = '0;
                    rowc_d   = '0;
                end
            end
            S_SCAN: begin
                // Outputs lag the scan counters by one register stage, so the
                // prescaler-0 cycle of each row becomes the blank ghost guard.
                if (psc_q != '0) begin
                    row_d = ~(8'b1 << rowc_q);
                    if (!dark) begin
                        colg_d = fail ? img_byte : 8'h00;
                        colr_d = fail ? 8'h00 : img_byte;
                    end
                end

                if (psc_q == PSC_LAST) begin
                    psc_d  = '0;
                    rowc_d = rowc_q + 3'd1;
                end else begin
                    psc_d = psc_q + 16'd1;
                end

                // A strobe on the boundary cycle bypasses the pending slot.
                if (boundary) begin
                    if (st) begin
                        cur_d    = num;
                        pend_v_d = 1'b0;
                    end else if (pend_v_q) begin
                        cur_d    = pend_q;
                        pend_v_d = 1'b0;
                    end
                end else if (st) begin
                    pend_d   = num;
                    pend_v_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            psc_q    <= '0;
            rowc_q   <= '0;
            cur_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            row_q    <= 8'hFF;
            colg_q   <= 8'h00;
            colr_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            psc_q    <= psc_d;
            rowc_q   <= rowc_d;
            cur_q    <= cur_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            row_q    <= row_d;
            colg_q   <= colg_d;
            colr_q   <= colr_d;
        end
    end

    assign row        = row_q;
    assign colg       = colg_q;
    assign colr       = colr_q;
    assign frame_done = boundary;

endmodule
